// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte-serial load/store unit bridging word requests to an 8-bit memory
module load_store_unit #(
  parameter int width_bytes = 2,
  parameter int addr_width  = 8,
  parameter int timeout     = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [addr_width-1:0]    req_addr,
  input  logic [8*width_bytes-1:0] req_wdata,
  input  logic                     req_read,
  input  logic                     req_write,
  output logic                     busy,
  output logic [8*width_bytes-1:0] resp_rdata,
  output logic                     resp_valid,
  output logic                     resp_err,
  output logic [addr_width-1:0]    mem_address,
  output logic [7:0]               mem_wdata,
  input  logic [7:0]               mem_rdata,
  output logic                     mem_read,
  output logic                     mem_write,
  input  logic                     mem_ready_r,
  input  logic                     mem_ready_w
);

  localparam int data_width = 8 * width_bytes;
  localparam int k_width    = (width_bytes > 1) ? $clog2(width_bytes) : 1;
  localparam int cnt_width  = $clog2(timeout + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, ERR} state_t;

  state_t                  state, state_next;
  logic [addr_width-1:0]   base_q, base_d;
  logic [data_width-1:0]   wdata_q, wdata_d;
  logic                    op_write_q, op_write_d;
  logic [k_width-1:0]      k_q, k_d, k_next;
  logic [cnt_width-1:0]    cnt_q, cnt_d;
  logic                    ready_match;

  logic                    busy_d, resp_valid_d, resp_err_d, mem_read_d, mem_write_d;
  logic [data_width-1:0]   resp_rdata_d;
  logic [addr_width-1:0]   mem_address_d;
  logic [7:0]              mem_wdata_d;

  assign k_next      = k_q + 1'b1;
  assign ready_match = op_write_q ? mem_ready_w : mem_ready_r;

  // Next state plus the registered output values belonging to the state being entered,
  // so each strobe/pulse becomes visible in the same cycle as its state.
  always_comb begin
    state_next    = state;
    base_d        = base_q;
    wdata_d       = wdata_q;
    op_write_d    = op_write_q;
    k_d           = k_q;
    cnt_d         = cnt_q;
    busy_d        = 1'b0;
    resp_valid_d  = 1'b0;
    resp_err_d    = 1'b0;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    resp_rdata_d  = resp_rdata;
    mem_address_d = mem_address;
    mem_wdata_d   = mem_wdata;

    case (state)
      IDLE: begin
        if (req_write || req_read) begin
          // A store wins when both request lines are high.
          base_d        = req_addr;
          wdata_d       = req_wdata;
          op_write_d    = req_write;
          k_d           = '0;
          mem_address_d = req_addr;
          mem_wdata_d   = req_wdata[7:0];
          mem_write_d   = req_write;
          mem_read_d    = !req_write;
          state_next    = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d      = '0;
        state_next = WAIT;
      end
      WAIT: begin
        if (ready_match) begin
          if (!op_write_q) begin
            resp_rdata_d[8*k_q +: 8] = mem_rdata;
          end
          if (k_q == k_width'(width_bytes - 1)) begin
            resp_valid_d = 1'b1;
            state_next   = DONE;
          end else begin
            k_d           = k_next;
            mem_address_d = base_q + addr_width'(k_next);
            mem_wdata_d   = wdata_q[8*k_next +: 8];
            mem_write_d   = op_write_q;
            mem_read_d    = !op_write_q;
            state_next    = ISSUE;
          end
        end else if (cnt_q == cnt_width'(timeout - 1)) begin
          resp_err_d = 1'b1;
          state_next = ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase

    busy_d = (state_next != IDLE);
  end

  // State, transaction context and output registers; reset aborts silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      base_q      <= '0;
      wdata_q     <= '0;
      op_write_q  <= 1'b0;
      k_q         <= '0;
      cnt_q       <= '0;
      busy        <= 1'b0;
      resp_valid  <= 1'b0;
      resp_err    <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      resp_rdata  <= '0;
      mem_address <= '0;
      mem_wdata   <= '0;
    end else begin
      state       <= state_next;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      op_write_q  <= op_write_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      busy        <= busy_d;
      resp_valid  <= resp_valid_d;
      resp_err    <= resp_err_d;
      mem_read    <= mem_read_d;
      mem_write   <= mem_write_d;
      resp_rdata  <= resp_rdata_d;
      mem_address <= mem_address_d;
      mem_wdata   <= mem_wdata_d;
    end
  end

endmodule
